pmu_pg_seq: RTL

Power-gating sequencer for the core power domain, located in the PMU beside the low-power-mode FSM. When the PMU requests STOP, it asserts the core reset, applies isolation, hands off to the core's sleep handshake and turns off the power switch. On wakeup it reverses that sequence. The reset and isolation phases use programmable dwell times, and the block waits for a real power-switch acknowledge before moving past the power phases. An early wakeup aborts a power-down that has not yet removed power.

---
 rtl/pmu_pg_pkg.sv | 31 +++
 rtl/pmu_pg_dly_cnt.sv | 36 +++
 rtl/pmu_pg_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/pmu_pg_pkg.sv
// Shared types and decode constants for the core power-gating sequencer.
// Output masks are indexed by the state encoding (bit n set = asserted in state n).
package pmu_pg_pkg;

    localparam int PG_DLY_W = 8;

    typedef enum logic [3:0] {
        PG_IDLE      = 4'd0,
        PG_RST_ON    = 4'd1,
        PG_ISO_ON    = 4'd2,
        PG_SLEEP_REQ = 4'd3,
        PG_PSW_OFF   = 4'd4,
        PG_OFF       = 4'd5,
        PG_PSW_ON    = 4'd6,
        PG_ISO_OFF   = 4'd7,
        PG_RST_OFF   = 4'd8
    } pg_state_t;

    localparam logic [15:0] PG_ISO_MASK    = 16'h007C;
    localparam logic [15:0] PG_SLEEP_MASK  = 16'h0078;
    localparam logic [15:0] PG_PSWOFF_MASK = 16'h0030;

    function automatic logic pg_in_mask(input logic [15:0] mask, input pg_state_t st);
        return mask[st];
    endfunction

    function automatic logic pg_is_timed(input pg_state_t st);
        return (st == PG_RST_ON) || (st == PG_ISO_ON) || (st == PG_ISO_OFF);
    endfunction

endpackage

// File: rtl/pmu_pg_dly_cnt.sv
// Loadable down-counter for the sequencer dwell times; holds at zero.
module pmu_pg_dly_cnt
    import pmu_pg_pkg::*;
#(
    parameter int DLY_W = PG_DLY_W
) (
    input  logic             pmu_clk,
    input  logic             pad_cpu_rst_b,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    output logic             zero
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DLY_W'(1);
        end
    end

    always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pmu_pg_seq.sv
// Core power-domain gating sequencer: reset, isolation, sleep handshake and
// power switch, reversed on wakeup, with early-wakeup abort before power removal.
module pmu_pg_seq
    import pmu_pg_pkg::*;
#(
    parameter int DLY_W = PG_DLY_W
) (
    input  logic             pmu_clk,
    input  logic             pad_cpu_rst_b,
    input  logic             pg_off_req,
    input  logic             pg_wakeup,
    input  logic [DLY_W-1:0] cfg_iso_dly,
    input  logic [DLY_W-1:0] cfg_pwr_dly,
    input  logic             corec_pmu_sleep_out,
    input  logic             psw_ack,
    output logic             pg_reset_b,
    output logic             pmu_corec_isolation,
    output logic             pmu_corec_sleep_in,
    output logic             psw_en,
    output logic             pg_busy,
    output logic             pg_done
);

    pg_state_t        state_q;
    pg_state_t        state_d;
    logic             pwr_armed_q;
    logic             pwr_armed_d;
    logic             cnt_load;
    logic [DLY_W-1:0] cnt_load_val;
    logic             cnt_zero;

    pmu_pg_dly_cnt #(.DLY_W(DLY_W)) u_dly_cnt (
        .pmu_clk       (pmu_clk),
        .pad_cpu_rst_b (pad_cpu_rst_b),
        .load          (cnt_load),
        .load_val      (cnt_load_val),
        .zero          (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        pwr_armed_d  = pwr_armed_q;
        cnt_load     = 1'b0;
        cnt_load_val = cfg_iso_dly;
        unique case (state_q)
            PG_IDLE:      if (pg_off_req && !pg_wakeup) state_d = PG_RST_ON;
            // Wakeup is checked ahead of timer expiry and the sleep ack.
            PG_RST_ON:    if (pg_wakeup) state_d = PG_RST_OFF;
                          else if (cnt_zero) state_d = PG_ISO_ON;
            PG_ISO_ON:    if (pg_wakeup) state_d = PG_ISO_OFF;
                          else if (cnt_zero) state_d = PG_SLEEP_REQ;
            PG_SLEEP_REQ: if (pg_wakeup) state_d = PG_ISO_OFF;
                          else if (corec_pmu_sleep_out) state_d = PG_PSW_OFF;
            PG_PSW_OFF:   if (!psw_ack) state_d = PG_OFF;
            PG_OFF: begin
                if (pg_wakeup) begin
                    state_d     = PG_PSW_ON;
                    pwr_armed_d = 1'b0;
                end
            end
            // Settle timer starts only once the switch reports power good.
            PG_PSW_ON: begin
                if (!pwr_armed_q) begin
                    if (psw_ack) begin
                        pwr_armed_d  = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = cfg_pwr_dly;
                    end
                end else if (cnt_zero) begin
                    state_d = PG_ISO_OFF;
                end
            end
            PG_ISO_OFF:   if (cnt_zero) state_d = PG_RST_OFF;
            PG_RST_OFF:   state_d = PG_IDLE;
            default:      state_d = PG_IDLE;
        endcase
        if ((state_d != state_q) && pg_is_timed(state_d)) begin
            cnt_load     = 1'b1;
            cnt_load_val = cfg_iso_dly;
        end
    end

    always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_q     <= PG_IDLE;
            pwr_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_armed_q <= pwr_armed_d;
        end
    end

    assign pg_reset_b          = (state_q == PG_IDLE) && pad_cpu_rst_b;
    assign pmu_corec_isolation = pg_in_mask(PG_ISO_MASK, state_q);
    assign pmu_corec_sleep_in  = pg_in_mask(PG_SLEEP_MASK, state_q);
    assign psw_en              = !pg_in_mask(PG_PSWOFF_MASK, state_q);
    assign pg_busy             = (state_q != PG_IDLE);
    assign pg_done             = (state_q == PG_RST_OFF);

endmodule
